// File: rtl/csr_timer_intc.sv
// csr_timer_intc: CH_N down-counting timers plus interrupt pending/enable/priority logic on the CSR bus.
// Define CSR_INTC_HW_EDGE_EN for sticky rising-edge capture of the hardware interrupt lines.
module csr_timer_intc #(
    parameter int TIMER_N     = 32,
    parameter int CH_N        = 2,
    parameter int HW_N        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5,
    localparam int P          = 3 + HW_N + CH_N,
    localparam int IDX_W      = $clog2(P)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic              csr_we,
    input  logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_wmask,
    output logic [31:0]       csr_rdata,
    input  logic [HW_N-1:0]   hw_int,
    input  logic              ipi_int,
    input  logic              gie,
    output logic [P-1:0]      pend,
    output logic              int_req,
    output logic [IDX_W-1:0]  int_idx
);

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [31:0] m);
        return (m & d) | (~m & old);
    endfunction

    logic [P-1:0]       inten_q;
    logic [1:0]         sw_pend_q;
    logic [CH_N-1:0]    tmr_pend_q;
    logic               ipi_q;
    logic [HW_N-1:0]    sync_q [SYNC_STAGES];
    logic [HW_N-1:0]    hw_pend;

    logic [CH_N-1:0]    en_q;
    logic [CH_N-1:0]    per_q;
    logic [TIMER_N-3:0] init_q [CH_N];
    logic [TIMER_N-1:0] tval_q [CH_N];

    logic [31:0]        tcfg_rd  [CH_N];
    logic [31:0]        tcfg_mrg [CH_N];
    logic [CH_N-1:0]    tcfg_wr;
    logic [CH_N-1:0]    ticlr_wr;
    logic [CH_N-1:0]    fire;
    logic               inten_wr;
    logic               pend_wr;
    logic [P-1:0]       masked;

    assign inten_wr = csr_we && (csr_addr == ADDR_W'(0));
    assign pend_wr  = csr_we && (csr_addr == ADDR_W'(1));

    // Hardware line synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= hw_int;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef CSR_INTC_HW_EDGE_EN
    logic [HW_N-1:0] hw_prev_q;
    logic [HW_N-1:0] hw_pend_q;
    logic [HW_N-1:0] hw_rise;
    logic [HW_N-1:0] hw_clr;

    assign hw_rise = sync_q[SYNC_STAGES-1] & ~hw_prev_q;
    assign hw_clr  = pend_wr ? (csr_wmask[HW_N+1:2] & csr_wdata[HW_N+1:2]) : '0;

    // A new edge overrides a clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_prev_q <= '0;
            hw_pend_q <= '0;
        end else begin
            hw_prev_q <= sync_q[SYNC_STAGES-1];
            hw_pend_q <= (hw_pend_q & ~hw_clr) | hw_rise;
        end
    end

    assign hw_pend = hw_pend_q;
`else
    assign hw_pend = sync_q[SYNC_STAGES-1];
`endif

    // Per-channel decode; a config write pre-empts the fire event of that cycle.
    always_comb begin
        for (int k = 0; k < CH_N; k++) begin
            tcfg_rd[k]  = 32'({init_q[k], per_q[k], en_q[k]});
            tcfg_mrg[k] = wmerge(tcfg_rd[k], csr_wdata, csr_wmask);
            tcfg_wr[k]  = csr_we && (csr_addr == ADDR_W'(4 + 4*k));
            ticlr_wr[k] = csr_we && (csr_addr == ADDR_W'(6 + 4*k)) && csr_wmask[0] && csr_wdata[0];
            fire[k]     = en_q[k] && (tval_q[k] == '0) && !tcfg_wr[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inten_q    <= '0;
            sw_pend_q  <= '0;
            tmr_pend_q <= '0;
            ipi_q      <= 1'b0;
            en_q       <= '0;
            per_q      <= '0;
            for (int k = 0; k < CH_N; k++) begin
                init_q[k] <= '0;
                tval_q[k] <= '0;
            end
        end else begin
            ipi_q <= ipi_int;
            if (inten_wr)
                inten_q <= (csr_wmask[P-1:0] & csr_wdata[P-1:0]) | (~csr_wmask[P-1:0] & inten_q);
            if (pend_wr)
                sw_pend_q <= (csr_wmask[1:0] & csr_wdata[1:0]) | (~csr_wmask[1:0] & sw_pend_q);
            for (int k = 0; k < CH_N; k++) begin
                if (tcfg_wr[k]) begin
                    en_q[k]   <= tcfg_mrg[k][0];
                    per_q[k]  <= tcfg_mrg[k][1];
                    init_q[k] <= tcfg_mrg[k][TIMER_N-1:2];
                    if (tcfg_mrg[k][0])
                        tval_q[k] <= {tcfg_mrg[k][TIMER_N-1:2], 2'b00};
                end else if (fire[k]) begin
                    if (per_q[k])
                        tval_q[k] <= {init_q[k], 2'b00};
                    else
                        en_q[k] <= 1'b0;
                end else if (en_q[k]) begin
                    tval_q[k] <= tval_q[k] - TIMER_N'(1);
                end

                if (fire[k])
                    tmr_pend_q[k] <= 1'b1;
                else if (ticlr_wr[k])
                    tmr_pend_q[k] <= 1'b0;
            end
        end
    end

    assign pend    = {ipi_q, tmr_pend_q, hw_pend, sw_pend_q};
    assign masked  = pend & inten_q;
    assign int_req = gie && (|masked);

    always_comb begin
        int_idx = '0;
        for (int i = 0; i < P; i++) begin
            if (masked[i]) int_idx = IDX_W'(i);
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_addr == ADDR_W'(0)) csr_rdata = 32'(inten_q);
        if (csr_addr == ADDR_W'(1)) csr_rdata = 32'(pend);
        for (int k = 0; k < CH_N; k++) begin
            if (csr_addr == ADDR_W'(4 + 4*k)) csr_rdata = tcfg_rd[k];
            if (csr_addr == ADDR_W'(5 + 4*k)) csr_rdata = 32'(tval_q[k]);
        end
    end

endmodule
